// File: rtl/axi4_lite_scoreboard.sv
// Emulator-resident checker: shadows every word written over the CPU command/data
// interface of the AXI4-lite master and compares each read-back beat against it.
module axi4_lite_scoreboard #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned REG_DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH      = 5,
    parameter int unsigned MEM_AW         = 6,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                      axi4_lite_aclk,
    input  logic                      axi4_lite_aresetn,
    input  logic                      WRITE,
    input  logic                      READ,
    input  logic                      DATA_VALID,
    input  logic [REG_DATA_WIDTH-1:0] DATA_IN,
    input  logic [LEN_WIDTH-1:0]      DATA_LENGTH,
    input  logic [ADDRESS_WIDTH-1:0]  CPU_ADDR,
    input  logic [REG_DATA_WIDTH-1:0] DATA_OUT,
    input  logic                      OUT_VALID,
    output logic [CNT_WIDTH-1:0]      error_count,
    output logic [CNT_WIDTH-1:0]      check_count,
    output logic [CNT_WIDTH-1:0]      proto_err_count,
    output logic [CNT_WIDTH-1:0]      unwritten_count,
    output logic                      mismatch,
    output logic                      first_err_valid,
    output logic [MEM_AW-1:0]         first_err_idx,
    output logic [REG_DATA_WIDTH-1:0] first_err_exp,
    output logic [REG_DATA_WIDTH-1:0] first_err_act
);

    localparam int unsigned Depth = 1 << MEM_AW;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StWrCap, StRdChk} state_e;

    state_e                    r_state;
    logic [MEM_AW-1:0]         r_base;
    logic [LEN_WIDTH-1:0]      r_len;
    logic [LEN_WIDTH-1:0]      r_beat;
    logic [TW-1:0]             r_timer;
    logic [REG_DATA_WIDTH-1:0] r_mem [Depth];
    logic [Depth-1:0]          r_vld;
    logic [CNT_WIDTH-1:0]      r_err_cnt;
    logic [CNT_WIDTH-1:0]      r_chk_cnt;
    logic [CNT_WIDTH-1:0]      r_proto_cnt;
    logic [CNT_WIDTH-1:0]      r_unwr_cnt;
    logic                      r_mismatch;
    logic                      r_first_vld;
    logic [MEM_AW-1:0]         r_first_idx;
    logic [REG_DATA_WIDTH-1:0] r_first_exp;
    logic [REG_DATA_WIDTH-1:0] r_first_act;

    logic                      w_cmd;
    logic                      w_len_zero;
    logic                      w_last;
    logic [MEM_AW-1:0]         w_idx;
    logic [REG_DATA_WIDTH-1:0] w_exp;
    logic                      w_exp_vld;
    logic                      w_wr_en;
    logic [MEM_AW-1:0]         w_wr_idx;
    logic                      w_rd_beat;
    logic                      w_idle_cyc;
    logic                      w_timeout;
    logic                      w_proto;
    logic                      w_unused;

    // Only the low MEM_AW address bits select a shadow entry.
    assign w_unused = ^CPU_ADDR[ADDRESS_WIDTH-1:MEM_AW];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        w_cmd      = WRITE | READ;
        w_len_zero = (DATA_LENGTH == '0);
        w_last     = (r_beat == r_len - LEN_WIDTH'(1));
        w_idx      = r_base + MEM_AW'(r_beat);
        w_exp      = r_mem[w_idx];
        w_exp_vld  = r_vld[w_idx];
        w_wr_en    = 1'b0;
        w_wr_idx   = w_idx;
        w_proto    = 1'b0;
        w_rd_beat  = (r_state == StRdChk) && OUT_VALID;
        w_idle_cyc = ((r_state == StWrCap) && !DATA_VALID) ||
                     ((r_state == StRdChk) && !OUT_VALID);
        w_timeout  = w_idle_cyc && (r_timer == TW'(TIMEOUT - 1));
        unique case (r_state)
            StIdle: begin
                if ((w_cmd && w_len_zero) || (WRITE && READ)) w_proto = 1'b1;
                if ((DATA_VALID && !WRITE) || OUT_VALID)      w_proto = 1'b1;
                if (WRITE && !w_len_zero && DATA_VALID) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = CPU_ADDR[MEM_AW-1:0];
                end
            end
            StWrCap: begin
                if (OUT_VALID || w_cmd) w_proto = 1'b1;
                w_wr_en = DATA_VALID;
            end
            StRdChk: begin
                if (DATA_VALID || w_cmd) w_proto = 1'b1;
            end
            default: ;
        endcase
        if (w_timeout) w_proto = 1'b1;
    end

    always_ff @(posedge axi4_lite_aclk or negedge axi4_lite_aresetn) begin
        if (!axi4_lite_aresetn) begin
            r_vld <= '0;
        end else if (w_wr_en) begin
            r_vld[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge axi4_lite_aclk) begin
        if (w_wr_en) r_mem[w_wr_idx] <= DATA_IN;
    end

    always_ff @(posedge axi4_lite_aclk or negedge axi4_lite_aresetn) begin
        if (!axi4_lite_aresetn) begin
            r_state     <= StIdle;
            r_base      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_timer     <= '0;
            r_err_cnt   <= '0;
            r_chk_cnt   <= '0;
            r_proto_cnt <= '0;
            r_unwr_cnt  <= '0;
            r_mismatch  <= 1'b0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
            r_first_exp <= '0;
            r_first_act <= '0;
        end else begin
            r_mismatch <= 1'b0;
            if (w_proto) r_proto_cnt <= sat_inc(r_proto_cnt);
            if (w_rd_beat) begin
                if (w_exp_vld) begin
                    r_chk_cnt <= sat_inc(r_chk_cnt);
                    if (DATA_OUT != w_exp) begin
                        r_err_cnt  <= sat_inc(r_err_cnt);
                        r_mismatch <= 1'b1;
                        if (!r_first_vld) begin
                            r_first_vld <= 1'b1;
                            r_first_idx <= w_idx;
                            r_first_exp <= w_exp;
                            r_first_act <= DATA_OUT;
                        end
                    end
                end else begin
                    r_unwr_cnt <= sat_inc(r_unwr_cnt);
                end
            end
            unique case (r_state)
                StIdle: begin
                    if (WRITE && !w_len_zero) begin
                        r_base  <= CPU_ADDR[MEM_AW-1:0];
                        r_len   <= DATA_LENGTH;
                        r_timer <= '0;
                        if (DATA_VALID) begin
                            // Beat 0 rode along with the command.
                            r_beat  <= LEN_WIDTH'(1);
                            r_state <= (DATA_LENGTH == LEN_WIDTH'(1)) ? StIdle : StWrCap;
                        end else begin
                            r_beat  <= '0;
                            r_state <= StWrCap;
                        end
                    end else if (READ && !w_len_zero) begin
                        r_base  <= CPU_ADDR[MEM_AW-1:0];
                        r_len   <= DATA_LENGTH;
                        r_beat  <= '0;
                        r_timer <= '0;
                        r_state <= StRdChk;
                    end
                end
                StWrCap, StRdChk: begin
                    if ((r_state == StWrCap) ? DATA_VALID : OUT_VALID) begin
                        r_beat  <= r_beat + LEN_WIDTH'(1);
                        r_timer <= '0;
                        if (w_last) r_state <= StIdle;
                    end else if (w_timeout) begin
                        r_state <= StIdle;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign error_count     = r_err_cnt;
    assign check_count     = r_chk_cnt;
    assign proto_err_count = r_proto_cnt;
    assign unwritten_count = r_unwr_cnt;
    assign mismatch        = r_mismatch;
    assign first_err_valid = r_first_vld;
    assign first_err_idx   = r_first_idx;
    assign first_err_exp   = r_first_exp;
    assign first_err_act   = r_first_act;

endmodule

// File: doc/axi4_lite_scoreboard.md
Name: axi4_lite_scoreboard

Overview:
- Synthesizable, emulator-resident checker. Sits downstream of the CPU-side stimulus/DUT pair.
- Snoops the CPU command/data interface of the AXI4-lite master top: WRITE, READ, DATA_VALID, DATA_IN, DATA_LENGTH, CPU_ADDR, DATA_OUT, OUT_VALID.
- Keeps a shadow memory of all written words and compares every read-back word against it.
- Exports error/check counters and first-failure capture for emulator probes.

Parameters:
ADDRESS_WIDTH, 32, CPU_ADDR width
REG_DATA_WIDTH, 32, data word width
LEN_WIDTH, 5, DATA_LENGTH width (legal lengths 1..16)
MEM_AW, 6, shadow index width (2^MEM_AW entries)
CNT_WIDTH, 16, width of all statistic counters
TIMEOUT, 255, max idle cycles inside a burst before abort

Ports:
axi4_lite_aclk  in  1  clock
axi4_lite_aresetn  in  1  reset, asynchronous, active-low
WRITE  in  1  write command strobe
READ  in  1  read command strobe
DATA_VALID  in  1  write beat valid
DATA_IN  in  REG_DATA_WIDTH  write beat data
DATA_LENGTH  in  LEN_WIDTH  burst length, sampled with the command
CPU_ADDR  in  ADDRESS_WIDTH  start address, sampled with the command
DATA_OUT  in  REG_DATA_WIDTH  read beat data from DUT
OUT_VALID  in  1  read beat valid
error_count  out  CNT_WIDTH  data mismatches, saturating
check_count  out  CNT_WIDTH  read beats compared, saturating
proto_err_count  out  CNT_WIDTH  protocol violations and timeouts, saturating
unwritten_count  out  CNT_WIDTH  reads of never-written entries, saturating
mismatch  out  1  one-cycle pulse on a data mismatch
first_err_valid  out  1  sticky; set on the first mismatch
first_err_idx  out  MEM_AW  shadow index of the first mismatch
first_err_exp  out  REG_DATA_WIDTH  expected data at the first mismatch
first_err_act  out  REG_DATA_WIDTH  actual data at the first mismatch

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. All shadow valid bits cleared; shadow data is don't-care.
- Reset mid-burst aborts the burst immediately with no counter update.
- Shadow memory: 2^MEM_AW words plus one valid bit per entry, read combinationally.
- Beat i of a command targets index (CPU_ADDR[MEM_AW-1:0] + i) mod 2^MEM_AW. Index wrap-around is legal.
- Aliasing across a live address span larger than 2^MEM_AW produces mismatches by construction.
- FSM states: IDLE, WR_CAP, RD_CHK.
- IDLE, command accept:
  - WRITE=1: latch base index and len = DATA_LENGTH; go to WR_CAP.
  - If DATA_VALID=1 in the same cycle, beat 0 is captured in that cycle.
  - READ=1 with WRITE=0: latch base/len; go to RD_CHK. OUT_VALID in the accept cycle is not a beat.
  - WRITE=1 and READ=1 together: write wins; proto_err +1.
  - DATA_LENGTH=0 on a command: command ignored, stay in IDLE, proto_err +1.
  - DATA_VALID=1 without WRITE: proto_err +1, data discarded.
  - OUT_VALID=1 in IDLE: proto_err +1, data discarded.
- WR_CAP:
  - Each cycle with DATA_VALID=1: shadow[base+beat] <= DATA_IN, valid bit set, beat +1, idle timer cleared.
  - After beat len-1 is written, go to IDLE (next-cycle accept allowed).
  - OUT_VALID in WR_CAP: proto_err +1.
  - A new WRITE/READ in WR_CAP is ignored and counts proto_err +1.
- RD_CHK:
  - Each cycle with OUT_VALID=1: compare DATA_OUT with shadow[base+beat].
  - Valid entry: check_count +1. On inequality: error_count +1, mismatch=1 for one cycle. If first_err_valid=0, capture idx/exp/act and set first_err_valid.
  - Invalid entry: unwritten_count +1; no compare.
  - beat +1 per OUT_VALID; after beat len-1, go to IDLE.
  - DATA_VALID in RD_CHK: proto_err +1.
- Timeout: idle timer counts cycles in WR_CAP/RD_CHK without a beat. On reaching TIMEOUT: proto_err +1, go to IDLE, remaining beats are dropped.
- Counters saturate at all-ones and never wrap. When two proto_err events occur in one cycle, the counter increments by 1.
- Latency: shadow write is visible to a read beat on the following cycle or later. mismatch and the counters update 1 cycle after the OUT_VALID sample.

Test Plan:
- Reset, then WRITE len=4 at addr 0x10 with DATA_IN A0..A3, then READ len=4 with DATA_OUT A0..A3 -> check_count=4, error_count=0, first_err_valid=0.
- Same write, read returns A0,A1,0xDEADBEEF,A3 -> error_count=1, mismatch pulses once, first_err_idx=0x12, first_err_exp=A2, first_err_act=0xDEADBEEF.
- MEM_AW=6: WRITE len=16 at addr 0x3C, then read back -> indices 0x3C..0x3F then 0x00..0x0B written and checked, check_count=16, error_count=0.
- READ len=3 at never-written addr 0x20 after reset -> unwritten_count=3, check_count=0.
- Protocol cases: WRITE and READ in the same cycle -> proto_err=1, FSM in WR_CAP. DATA_LENGTH=0 -> proto_err=2, FSM stays IDLE. Stray OUT_VALID in IDLE -> proto_err=3.
- READ len=4 with only 2 OUT_VALID beats, then silence -> after TIMEOUT=255 idle cycles proto_err +1, FSM in IDLE. Assert reset mid-WR_CAP -> all counters 0, valid bits cleared.
